// File: rtl/riscv_ahb3_ext_responder.sv
// rtl/riscv_ahb3_ext_responder.sv - AHB3-Lite responder with a word-addressed SRAM window
// Ports: HCLK/HRESETn clock and async active-low reset; HSEL, HADDR, HWRITE, HSIZE,
// HBURST, HPROT, HTRANS, HMASTLOCK, HREADY address phase; HWDATA write data;
// HRDATA, HREADYOUT, HRESP data-phase response.
module riscv_ahb3_ext_responder #(
    parameter int                    HADDR_SIZE  = 32,
    parameter int                    HDATA_SIZE  = 32,
    parameter int                    MEM_DEPTH   = 1024,
    parameter logic [HADDR_SIZE-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HMASTLOCK,
    input  logic                  HREADY,
    output logic [HDATA_SIZE-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP
);
    localparam int                    IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [HADDR_SIZE:0]   WINDOW = (HADDR_SIZE+1)'(MEM_DEPTH) << 2;
    localparam logic [3:0]            WS4    = 4'(WAIT_STATES);

    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

    state_t                  state, state_nxt;
    logic [3:0]              wait_cnt;
    logic [IDX_W-1:0]        lat_idx;
    logic [1:0]              lat_lane;
    logic [1:0]              lat_size;
    logic                    lat_write;
    logic [HDATA_SIZE-1:0]   mem [MEM_DEPTH];

    logic [HADDR_SIZE-1:0]   offset;
    logic [IDX_W-1:0]        new_idx;
    logic [IDX_W-1:0]        rd_idx;
    logic                    ready_state;
    logic                    accept;
    logic                    addr_err;
    logic                    rd_load;
    logic                    mem_we;
    logic [HDATA_SIZE-1:0]   wr_word;
    logic [HDATA_SIZE-1:0]   rd_word;
    logic                    unused_ok;

    assign unused_ok = ^{HBURST, HPROT, HMASTLOCK};

    // Offset wraps for addresses below the base, so one unsigned compare covers both ends.
    assign offset   = HADDR - BASE_ADDR;
    assign new_idx  = offset[IDX_W+1:2];
    assign addr_err = (HSIZE > 3'd2)
                    | ((HSIZE == 3'd1) & HADDR[0])
                    | ((HSIZE == 3'd2) & (|HADDR[1:0]))
                    | ({1'b0, offset} >= WINDOW);

    // Only states that drive HREADYOUT high can end a data phase and take a new address.
    assign ready_state = (state == ST_IDLE) | (state == ST_DATA) | (state == ST_ERR2);
    assign accept      = HSEL & HREADY & HTRANS[1] & ready_state;

    always_comb begin
        state_nxt = state;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        case (state)
            ST_WAIT: begin
                HREADYOUT = 1'b0;
                if (wait_cnt == 4'd1) state_nxt = ST_DATA;
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                state_nxt = ST_ERR2;
            end
            default: begin
                HRESP = (state == ST_ERR2);
                if (accept) begin
                    if (addr_err)             state_nxt = ST_ERR1;
                    else if (WAIT_STATES > 0) state_nxt = ST_WAIT;
                    else                      state_nxt = ST_DATA;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    // Byte-merge of the write in its DATA cycle; also the forwarding source for a
    // read accepted on the same edge.
    always_comb begin
        wr_word = mem[lat_idx];
        case (lat_size)
            2'd0:    wr_word[{lat_lane, 3'b000} +: 8]     = HWDATA[{lat_lane, 3'b000} +: 8];
            2'd1:    wr_word[{lat_lane[1], 4'b0000} +: 16] = HWDATA[{lat_lane[1], 4'b0000} +: 16];
            default: wr_word = HWDATA;
        endcase
    end

    assign mem_we = (state == ST_DATA) & lat_write;

    // Read data is registered on the edge that enters DATA: the accept edge with no
    // wait states, otherwise the last WAIT edge.
    assign rd_idx  = (WAIT_STATES == 0) ? new_idx : lat_idx;
    assign rd_load = (WAIT_STATES == 0) ? (accept & ~addr_err & ~HWRITE)
                                        : ((state == ST_WAIT) & (wait_cnt == 4'd1) & ~lat_write);
    assign rd_word = (mem_we && (lat_idx == rd_idx)) ? wr_word : mem[rd_idx];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            wait_cnt  <= 4'd0;
            lat_idx   <= '0;
            lat_lane  <= 2'd0;
            lat_size  <= 2'd0;
            lat_write <= 1'b0;
            HRDATA    <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_WAIT) wait_cnt <= wait_cnt - 4'd1;
            if (accept) begin
                lat_idx   <= new_idx;
                lat_lane  <= HADDR[1:0];
                lat_size  <= HSIZE[1:0];
                lat_write <= HWRITE;
                wait_cnt  <= WS4;
            end
            if (rd_load) HRDATA <= rd_word;
        end
    end

    // No reset on the array: contents survive HRESETn, and a reset forces IDLE so an
    // interrupted write never lands.
    always_ff @(posedge HCLK) begin
        if (mem_we) mem[lat_idx] <= wr_word;
    end
endmodule
